// File: rtl/rf_writeback_arbiter.sv
// Single write-port arbiter for the pipeline5 register file: ALU results vs. a long-latency FIFO,
// plus the busy-register scoreboard. Define RF_WB_BYPASS_EN to drive the byp_* forwarding outputs.
module rf_writeback_arbiter #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned QUEUE_DEPTH  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [WORD_SIZE-1:0]  alu_data,
  output logic                  alu_stall,
  input  logic                  ldu_valid,
  input  logic [ADDR_WIDTH-1:0] ldu_rd,
  input  logic [WORD_SIZE-1:0]  ldu_data,
  output logic                  ldu_ready,
  output logic                  we3,
  output logic [ADDR_WIDTH-1:0] wr_addr3,
  output logic [WORD_SIZE-1:0]  wr_data3,
  output logic [31:0]           busy_vec,
  output logic                  byp_valid,
  output logic [ADDR_WIDTH-1:0] byp_addr,
  output logic [WORD_SIZE-1:0]  byp_data
);

  localparam int unsigned NumRegs = 32;
  localparam int unsigned PtrW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CntW-1:0]    DepthCnt  = CntW'(QUEUE_DEPTH);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [0:0] {StNormal, StDrain} arb_state_e;

  arb_state_e            state_q, state_d;
  logic [StarveW-1:0]    starve_cnt_q, starve_cnt_d;
  logic [ADDR_WIDTH-1:0] fifo_rd_q   [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0]  fifo_data_q [QUEUE_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic [NumRegs-1:0]    busy_q, busy_d;
  logic                  we3_q;
  logic [ADDR_WIDTH-1:0] wr_addr3_q;
  logic [WORD_SIZE-1:0]  wr_data3_q;

  logic                  fifo_empty, fifo_full;
  logic                  push, pop, issue_fire;
  logic                  alu_win, fifo_win, wb_valid;
  logic [ADDR_WIDTH-1:0] head_rd, wb_rd;
  logic [WORD_SIZE-1:0]  head_data, wb_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DepthCnt);
  assign head_rd    = fifo_rd_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  assign ldu_ready   = !fifo_full;
  assign push        = ldu_valid && ldu_ready;
  assign issue_ready = !busy_q[issue_rd] && (outstanding_q < DepthCnt);
  assign issue_fire  = issue_valid && issue_ready;

  // Drain gives the FIFO priority; an empty FIFO there lets the ALU through rather than idling.
  always_comb begin
    alu_win  = 1'b0;
    fifo_win = 1'b0;
    unique case (state_q)
      StNormal: begin
        if (alu_valid) begin
          alu_win = 1'b1;
        end else if (!fifo_empty) begin
          fifo_win = 1'b1;
        end
      end
      StDrain: begin
        if (!fifo_empty) begin
          fifo_win = 1'b1;
        end else if (alu_valid) begin
          alu_win = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pop       = fifo_win;
  assign alu_stall = alu_valid && !alu_win;
  assign wb_valid  = alu_win || fifo_win;
  assign wb_rd     = alu_win ? alu_rd : head_rd;
  assign wb_data   = alu_win ? alu_data : head_data;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop) begin
      starve_cnt_d = '0;
    end else if (!fifo_empty && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + StarveW'(1);
    end
  end

  // Switching on the next count lets the FIFO win on its (STARVE_LIMIT+1)-th waiting cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StNormal: if (!pop && (starve_cnt_d == StarveMax)) state_d = StDrain;
      StDrain:  if (pop) state_d = StNormal;
      default:  state_d = StNormal;
    endcase
  end

  always_comb begin
    count_d       = count_q + CntW'(push) - CntW'(pop);
    outstanding_d = outstanding_q + CntW'(issue_fire)
                    - CntW'(pop && (outstanding_q != '0));
  end

  always_comb begin
    busy_d = busy_q;
    if (issue_fire && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (pop) begin
      busy_d[head_rd] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StNormal;
      starve_cnt_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      busy_q        <= '0;
      we3_q         <= 1'b0;
      wr_addr3_q    <= '0;
      wr_data3_q    <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      busy_q        <= busy_d;
      if (push) begin
        fifo_rd_q[wr_ptr_q]   <= ldu_rd;
        fifo_data_q[wr_ptr_q] <= ldu_data;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      // x0 results are consumed but never written.
      we3_q <= wb_valid && (wb_rd != '0);
      if (wb_valid) begin
        wr_addr3_q <= wb_rd;
        wr_data3_q <= wb_data;
      end
    end
  end

  assign we3      = we3_q;
  assign wr_addr3 = wr_addr3_q;
  assign wr_data3 = wr_data3_q;
  assign busy_vec = busy_q;

`ifdef RF_WB_BYPASS_EN
  assign byp_valid = we3_q && (wr_addr3_q != '0);
  assign byp_addr  = wr_addr3_q;
  assign byp_data  = wr_data3_q;
`else
  assign byp_valid = 1'b0;
  assign byp_addr  = '0;
  assign byp_data  = '0;
`endif

  alu_rd_not_busy_a: assert property (@(posedge clk) disable iff (reset)
    (alu_valid && (alu_rd != '0)) |-> !busy_q[alu_rd]);

  ldu_rd_busy_a: assert property (@(posedge clk) disable iff (reset)
    (ldu_valid && (ldu_rd != '0)) |-> busy_q[ldu_rd]);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized and directed bench for rf_writeback_arbiter against a queue-based reference model.
module tb_rf_writeback_arbiter;

  localparam int QD = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        ldu_valid = 1'b0;
  logic [4:0]  ldu_rd = '0;
  logic [31:0] ldu_data = '0;
  logic        ldu_ready;
  logic        we3;
  logic [4:0]  wr_addr3;
  logic [31:0] wr_data3;
  logic [31:0] busy_vec;
  logic        byp_valid;
  logic [4:0]  byp_addr;
  logic [31:0] byp_data;

  rf_writeback_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .ldu_valid  (ldu_valid),
    .ldu_rd     (ldu_rd),
    .ldu_data   (ldu_data),
    .ldu_ready  (ldu_ready),
    .we3        (we3),
    .wr_addr3   (wr_addr3),
    .wr_data3   (wr_data3),
    .busy_vec   (busy_vec),
    .byp_valid  (byp_valid),
    .byp_addr   (byp_addr),
    .byp_data   (byp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  logic [31:0] m_busy;
  int          m_out, m_starve;
  bit          m_drain;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_fire, m_push;
  bit          e_issue_ready, e_alu_stall, e_ldu_ready, alu_wins, fifo_wins;

  int   n_checks = 0;
  int   n_fail = 0;
  bit   last_stall = 1'b0;
  logic [4:0] awaiting[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_comb();
    e_ldu_ready   = (m_q.size() < QD);
    e_issue_ready = !m_busy[issue_rd] && (m_out < QD);
    alu_wins      = alu_valid && (!m_drain || m_q.size() == 0);
    fifo_wins     = !alu_wins && (m_q.size() > 0);
    e_alu_stall   = alu_valid && !alu_wins;
  endtask

  task automatic model_seq();
    ent_t h;
    int   nq;
    nq = m_q.size();
    if (reset) begin
      m_q.delete();
      m_busy = '0; m_out = 0; m_starve = 0; m_drain = 0;
      m_we = 0; m_addr = '0; m_data = '0; m_fire = 0; m_push = 0;
      return;
    end
    m_fire = issue_valid && e_issue_ready;
    m_push = ldu_valid && e_ldu_ready;
    m_we = 0;
    if (alu_wins) begin
      m_we = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
    end else if (fifo_wins) begin
      h = m_q.pop_front();
      m_we = (h.rd != 0); m_addr = h.rd; m_data = h.data;
      m_busy[h.rd] = 1'b0;
      if (m_out > 0) m_out--;
      m_starve = 0;
      m_drain = 0;
    end
    if (!fifo_wins && nq > 0) begin
      if (m_starve < SL) m_starve++;
      if (m_starve == SL) m_drain = 1;
    end
    if (m_fire) begin
      if (issue_rd != 0) m_busy[issue_rd] = 1'b1;
      m_out++;
    end
    if (m_push) begin
      h.rd = ldu_rd; h.data = ldu_data;
      m_q.push_back(h);
    end
    m_busy[0] = 1'b0;
  endtask

  // One clock: check comb outputs before the edge, registered outputs just after it.
  task automatic tick();
    #1;
    model_comb();
    if (!reset) begin
      check_eq("issue_ready", issue_ready, e_issue_ready);
      check_eq("alu_stall", alu_stall, e_alu_stall);
      check_eq("ldu_ready", ldu_ready, e_ldu_ready);
    end
    last_stall = alu_stall;
    model_seq();
    @(posedge clk);
    #1;
    check_eq("we3", we3, m_we);
    if (m_we) begin
      check_eq("wr_addr3", wr_addr3, m_addr);
      check_eq("wr_data3", wr_data3, m_data);
    end
    check_eq("busy_vec", busy_vec, m_busy);
`ifdef RF_WB_BYPASS_EN
    check_eq("byp_valid", byp_valid, m_we);
    if (m_we) begin
      check_eq("byp_addr", byp_addr, m_addr);
      check_eq("byp_data", byp_data, m_data);
    end
`else
    check_eq("byp_zero", {byp_valid, byp_addr, byp_data}, '0);
`endif
  endtask

  task automatic idle();
    issue_valid = 0; alu_valid = 0; ldu_valid = 0;
    tick();
  endtask

  task automatic alu_next();
    if (!last_stall) begin
      alu_rd   = 5'($urandom_range(1, 8));
      alu_data = $urandom;
    end
    alu_valid = 1;
  endtask

  initial begin
    int stall_at, n_stall;
    logic [4:0] held_rd;

    // Reset with a load presented
    reset = 1; ldu_valid = 1; ldu_rd = 5'd3; ldu_data = 32'hABCD;
    tick();
    tick();
    reset = 0; ldu_valid = 0;
    check_eq("rst_we3", we3, 0);
    check_eq("rst_busy", busy_vec, 0);
    #1;
    check_eq("rst_ldu_ready", ldu_ready, 1);
    check_eq("rst_alu_stall", alu_stall, 0);
    idle();

    // ALU only
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    check_eq("alu_we3", we3, 1);
    check_eq("alu_addr", wr_addr3, 5);
    check_eq("alu_data", wr_data3, 32'hDEADBEEF);
    idle();

    // Load path and blocked reissue
    issue_valid = 1; issue_rd = 5'd7;
    tick();
    check_eq("ld_busy_set", busy_vec[7], 1);
    ldu_valid = 1; ldu_rd = 5'd7; ldu_data = 32'h1234;
    #1;
    check_eq("ld_reissue_blocked", issue_ready, 0);
    tick();
    issue_valid = 0; ldu_valid = 0;
    tick();
    check_eq("ld_we3", we3, 1);
    check_eq("ld_addr", wr_addr3, 7);
    check_eq("ld_data", wr_data3, 32'h1234);
    check_eq("ld_busy_clr", busy_vec[7], 0);
    idle();

    // Starvation with continuous ALU traffic
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    stall_at = -1; n_stall = 0; held_rd = '0;
    for (int i = 0; i < 12; i++) begin
      alu_next();
      ldu_valid = (i == 0); ldu_rd = 5'd9; ldu_data = 32'h99;
      tick();
      if (last_stall) begin
        n_stall++;
        if (stall_at < 0) begin stall_at = i; held_rd = alu_rd; end
      end
      if (i == stall_at) check_eq("starve_fifo_wr", wr_addr3, 9);
      if (stall_at >= 0 && i == stall_at + 1) check_eq("starve_alu_after", wr_addr3, held_rd);
    end
    check_eq("starve_cycle", stall_at, SL + 1);
    check_eq("starve_stall_count", n_stall, 1);
    idle();

    // x0 writes from both sources
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h5555;
    issue_valid = 1; issue_rd = 5'd0;
    tick();
    check_eq("x0_alu_we3", we3, 0);
    alu_valid = 0; issue_valid = 0;
    ldu_valid = 1; ldu_rd = 5'd0; ldu_data = 32'h6666;
    tick();
    ldu_valid = 0;
    tick();
    check_eq("x0_ldu_we3", we3, 0);
    #1;
    check_eq("x0_ldu_ready", ldu_ready, 1);
    idle();

    // Push and pop in the same cycle
    issue_valid = 1; issue_rd = 5'd20; tick();
    issue_rd = 5'd21; tick();
    issue_valid = 0;
    ldu_valid = 1; ldu_rd = 5'd20; ldu_data = 32'h2020; tick();
    ldu_rd = 5'd21; ldu_data = 32'h2121; tick();
    check_eq("pp_pop_addr", wr_addr3, 20);
    ldu_valid = 0;
    tick();
    check_eq("pp_second_addr", wr_addr3, 21);
    idle();

    // Fill the FIFO under ALU pressure
    issue_valid = 1; issue_rd = 5'd22; tick();
    issue_rd = 5'd23; tick();
    issue_valid = 0;
    for (int i = 0; i < 14; i++) begin
      alu_next();
      ldu_valid = (i < 2); ldu_rd = (i == 0) ? 5'd22 : 5'd23; ldu_data = $urandom;
      if (i == 2) begin
        #1;
        check_eq("full_ldu_ready", ldu_ready, 0);
      end
      tick();
    end
    idle();
    idle();

    // Randomized traffic with one mid-run reset
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc == 400) begin
        reset = 1; issue_valid = 0; alu_valid = 0; ldu_valid = 0;
        tick();
        reset = 0;
        awaiting.delete();
        last_stall = 0;
        continue;
      end
      if (!last_stall) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 15));
        alu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
      ldu_valid   = (awaiting.size() > 0) && ($urandom_range(0, 1) == 1);
      ldu_rd      = (awaiting.size() > 0) ? awaiting[0] : 5'd0;
      ldu_data    = $urandom;
      tick();
      if (m_push) void'(awaiting.pop_front());
      if (m_fire) awaiting.push_back(issue_rd);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
